// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM arbiter (sram_vga_arbiter) and its I/O phy.
package sram_arb_pkg;

   localparam int DEF_ADDR_W    = 18;
   localparam int DEF_DATA_W    = 8;
   localparam int ACK_PULSE_CYC = 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_ACC   = 3'd1,
      S_WR_SETUP = 3'd2,
      S_WR_STB   = 3'd3,
      S_WR_HOLD  = 3'd4
   } arb_state_t;

endpackage

// File: rtl/sram_io_phy.sv
// SRAM pin layer: registered strobes/address, tristate write data and read capture.
// Driven by single-cycle event strobes from the arbiter FSM.
module sram_io_phy
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              ld_rd,
   input  logic              ld_wr,
   input  logic              stb_on,
   input  logic              stb_off,
   input  logic              rd_done,
   input  logic              hold_end,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic              sram_we_n,
   output logic              sram_oe_n,
   output logic              sram_ce_n
);

   logic [DATA_W-1:0] dout;
   logic              drv_en;

   // Release is asynchronous with reset so an abandoned write never keeps the bus.
   assign sram_data = drv_en ? dout : {DATA_W{1'bz}};

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         sram_addr <= '0;
         dout      <= '0;
         drv_en    <= 1'b0;
         sram_we_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_ce_n <= 1'b1;
         rd_data   <= '0;
      end else begin
         sram_ce_n <= 1'b0;
         if (ld_rd) begin
            sram_addr <= rd_addr;
            sram_oe_n <= 1'b0;
         end
         if (ld_wr) begin
            sram_addr <= wr_addr;
            dout      <= wr_data;
            drv_en    <= 1'b1;
         end
         if (stb_on)
            sram_we_n <= 1'b0;
         if (stb_off)
            sram_we_n <= 1'b1;
         if (rd_done) begin
            rd_data   <= sram_data;
            sram_oe_n <= 1'b1;
         end
         if (hold_end)
            drv_en <= 1'b0;
      end
   end

endmodule

// File: rtl/sram_vga_arbiter.sv
// Two-port (VGA read / frame write) arbiter and timing sequencer for the shared async SRAM.
// Optional stall statistics output wr_stall_cnt under `define SRAM_ARB_STATS_EN.
//
// state      | meaning
// S_IDLE     | bus turnaround; arbitration between rd_req and wr_req
// S_RD_ACC   | oe_n low, ACCESS_CYC cycles, capture on last edge
// S_WR_SETUP | address/data driven, we_n high for address setup
// S_WR_STB   | we_n low for ACCESS_CYC cycles
// S_WR_HOLD  | we_n high, data still driven, wr_ack pulses
module sram_vga_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int ACCESS_CYC    = 2,
   parameter int RD_STREAK_MAX = 4
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic              sram_we_n,
   output logic              sram_oe_n,
   output logic              sram_ce_n
`ifdef SRAM_ARB_STATS_EN
   ,
   output logic [15:0]       wr_stall_cnt
`endif
);

   localparam int CNT_W = $clog2(ACCESS_CYC + 1);
   localparam int STK_W = $clog2(RD_STREAK_MAX + 1);
   localparam int PW    = ACK_PULSE_CYC;
   localparam logic [CNT_W-1:0] ACC_LAST   = CNT_W'(ACCESS_CYC - 1);
   localparam logic [STK_W-1:0] STREAK_SAT = STK_W'(RD_STREAK_MAX);

   arb_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic [STK_W-1:0]  streak;
   logic [PW-1:0]     vld_sh;
   logic [PW-1:0]     ack_sh;

   logic grant_r, grant_w, acc_last;
   logic rd_done, stb_on, stb_end, hold_end;

   // Reads win by default; a write is forced once the read streak saturates.
   assign grant_w  = (state == S_IDLE) && wr_req && (!rd_req || (streak == STREAK_SAT));
   assign grant_r  = (state == S_IDLE) && rd_req && !grant_w;
   assign acc_last = (cnt == ACC_LAST);
   assign rd_done  = (state == S_RD_ACC) && acc_last;
   assign stb_on   = (state == S_WR_SETUP);
   assign stb_end  = (state == S_WR_STB) && acc_last;
   assign hold_end = (state == S_WR_HOLD);

   assign rd_valid = |vld_sh;
   assign wr_ack   = |ack_sh;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state  <= S_IDLE;
         cnt    <= '0;
         streak <= '0;
         vld_sh <= '0;
         ack_sh <= '0;
      end else begin
         vld_sh <= PW'({vld_sh, rd_done});
         ack_sh <= PW'({ack_sh, stb_end});

         if (!wr_req || grant_w)
            streak <= '0;
         else if (grant_r && (streak != STREAK_SAT))
            streak <= streak + STK_W'(1);

         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (grant_w)
                  state <= S_WR_SETUP;
               else if (grant_r)
                  state <= S_RD_ACC;
            end
            S_RD_ACC: begin
               if (acc_last) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_WR_SETUP: begin
               state <= S_WR_STB;
               cnt   <= '0;
            end
            S_WR_STB: begin
               if (acc_last) begin
                  state <= S_WR_HOLD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_WR_HOLD: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef SRAM_ARB_STATS_EN
   logic in_wr_state;
   assign in_wr_state = (state == S_WR_SETUP) || (state == S_WR_STB) || (state == S_WR_HOLD);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)
         wr_stall_cnt <= '0;
      else if (wr_req && !in_wr_state && !grant_w && (wr_stall_cnt != 16'hFFFF))
         wr_stall_cnt <= wr_stall_cnt + 16'd1;
   end
`endif

   sram_io_phy #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_phy (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .ld_rd     (grant_r),
      .ld_wr     (grant_w),
      .stb_on    (stb_on),
      .stb_off   (stb_end),
      .rd_done   (rd_done),
      .hold_end  (hold_end),
      .rd_addr   (rd_addr),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data),
      .sram_addr (sram_addr),
      .sram_data (sram_data),
      .sram_we_n (sram_we_n),
      .sram_oe_n (sram_oe_n),
      .sram_ce_n (sram_ce_n)
   );

endmodule

// File: tb/tb_sram_vga_arbiter.sv
// Directed bench for sram_vga_arbiter with a cycle-sampled async SRAM model.
module tb_sram_vga_arbiter;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        rd_req, wr_req;
   logic [17:0] rd_addr, wr_addr;
   logic [7:0]  wr_data;
   logic        rd_valid, wr_ack;
   logic [7:0]  rd_data;
   logic [17:0] sram_addr;
   wire  [7:0]  sram_data;
   logic        sram_we_n, sram_oe_n, sram_ce_n;
`ifdef SRAM_ARB_STATS_EN
   logic [15:0] wr_stall_cnt;
`endif

   logic [7:0]  mem [0:262143];
   logic        pre_we;
   logic [17:0] pre_a;
   logic [7:0]  pre_d;
   logic [7:0]  ZB;

   int n_checks = 0;
   int n_err    = 0;
   int rv_cnt   = 0;
   int wa_cnt   = 0;
   int inv_bad  = 0;

   always #5 CLK = ~CLK;

   sram_vga_arbiter dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .sram_addr (sram_addr),
      .sram_data (sram_data),
      .sram_we_n (sram_we_n),
      .sram_oe_n (sram_oe_n),
      .sram_ce_n (sram_ce_n)
`ifdef SRAM_ARB_STATS_EN
      ,
      .wr_stall_cnt (wr_stall_cnt)
`endif
   );

   // SRAM model: drives while selected and output-enabled, stores on clock edges with we_n low.
   assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'bz;

   always @(posedge CLK) begin
      if (!sram_ce_n && !sram_we_n)
         mem[sram_addr] <= sram_data;
      else if (pre_we)
         mem[pre_a] <= pre_d;
   end

   always @(posedge CLK) begin
      if (rd_valid) rv_cnt++;
      if (wr_ack) wa_cnt++;
   end

   always @(negedge CLK)
      if (!sram_oe_n && !sram_we_n) inv_bad++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_read(input logic [17:0] a, input logic [7:0] exp, input string tag);
      int lat, oe_low, we_low;
      lat = 0; oe_low = 0; we_low = 0;
      rd_addr = a;
      rd_req  = 1'b1;
      while (lat < 20) begin
         @(posedge CLK); #1;
         lat++;
         if (!sram_oe_n) oe_low++;
         if (!sram_we_n) we_low++;
         if (rd_valid) break;
      end
      rd_req = 1'b0;
      check({tag, "_lat"}, lat, 3);
      check({tag, "_data"}, rd_data, exp);
      check({tag, "_oelow"}, oe_low, 2);
      check({tag, "_welow"}, we_low, 0);
      @(posedge CLK); #1;
      check({tag, "_vld_pulse"}, rd_valid, 1'b0);
      check({tag, "_oe_off"}, sram_oe_n, 1'b1);
   endtask

   task automatic do_write(input logic [17:0] a, input logic [7:0] d, input string tag);
      int lat, we_low, bad;
      lat = 0; we_low = 0; bad = 0;
      wr_addr = a;
      wr_data = d;
      wr_req  = 1'b1;
      while (lat < 20) begin
         @(posedge CLK); #1;
         lat++;
         if (!sram_we_n) we_low++;
         if (sram_addr !== a || sram_data !== d || sram_oe_n !== 1'b1) bad++;
         if (wr_ack) break;
      end
      wr_req = 1'b0;
      check({tag, "_lat"}, lat, 4);
      check({tag, "_welow"}, we_low, 2);
      check({tag, "_stable"}, bad, 0);
      @(posedge CLK); #1;
      check({tag, "_ack_pulse"}, wr_ack, 1'b0);
      check({tag, "_bus_rel"}, sram_data, ZB);
   endtask

   initial begin
      logic [9:0] pat;
      int nev, rv0, wa0;
`ifdef SRAM_ARB_STATS_EN
      logic [15:0] st0, st_at_w;
      logic        st_seen;
`endif
      ZB = 8'bz;
      RSTn = 1'b0;
      rd_req = 1'b0; wr_req = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      pre_we = 1'b1; pre_a = 18'h12C00; pre_d = 8'hEF;
      repeat (2) @(posedge CLK);
      #1;
      pre_we = 1'b0;

      check("rst_we_n", sram_we_n, 1'b1);
      check("rst_oe_n", sram_oe_n, 1'b1);
      check("rst_ce_n", sram_ce_n, 1'b1);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_wr_ack", wr_ack, 1'b0);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_addr", sram_addr, 18'h0);
      check("rst_bus", sram_data, ZB);
`ifdef SRAM_ARB_STATS_EN
      check("rst_stall", wr_stall_cnt, 16'h0);
`endif

      RSTn = 1'b1;
      @(posedge CLK); #1;
      check("ce_after_rst", sram_ce_n, 1'b0);
      check("idle_oe_n", sram_oe_n, 1'b1);

      do_read(18'h12C00, 8'hEF, "rd1");

      do_write(18'd76799, 8'h2F, "wr1");
      check("rd_data_held", rd_data, 8'hEF);
      do_read(18'd76799, 8'h2F, "rb1");

      // Both requests held: reads win until the streak saturates at 4.
      rd_addr = 18'h12C00;
      wr_addr = 18'h00100;
      wr_data = 8'h5A;
      pat = '0;
      nev = 0;
`ifdef SRAM_ARB_STATS_EN
      st0 = wr_stall_cnt;
      st_at_w = '0;
      st_seen = 1'b0;
`endif
      rd_req = 1'b1;
      wr_req = 1'b1;
      for (int c = 0; c < 45 && nev < 10; c++) begin
         @(posedge CLK); #1;
         if (rd_valid) begin
            pat = {pat[8:0], 1'b0};
            nev++;
         end
         if (wr_ack) begin
            pat = {pat[8:0], 1'b1};
            nev++;
`ifdef SRAM_ARB_STATS_EN
            if (!st_seen) begin
               st_at_w = wr_stall_cnt - st0;
               st_seen = 1'b1;
            end
`endif
         end
      end
      rd_req = 1'b0;
      wr_req = 1'b0;
      check("arb_nev", nev, 10);
      check("arb_pattern", pat, 10'b0000100001);
`ifdef SRAM_ARB_STATS_EN
      check("stall_cnt", st_at_w, 16'd12);
`endif
      repeat (8) @(posedge CLK);
      #1;
      check("arb_drain_bus", sram_data, ZB);

      // Reset during the write strobe abandons the write.
      do_write(18'h00ABC, 8'h11, "wpre");
      wa0 = wa_cnt;
      wr_addr = 18'h00ABC;
      wr_data = 8'h99;
      wr_req  = 1'b1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check("rst_mid_stb", sram_we_n, 1'b0);
      #2;
      RSTn = 1'b0;
      #1;
      check("rst_mid_we", sram_we_n, 1'b1);
      check("rst_mid_bus", sram_data, ZB);
      check("rst_mid_ack", wr_ack, 1'b0);
      check("rst_mid_ce", sram_ce_n, 1'b1);
      wr_req = 1'b0;
      @(posedge CLK); #1;
      RSTn = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      check("rst_mid_no_ack", wa_cnt - wa0, 0);
      do_read(18'h00ABC, 8'h11, "rst_mem");

      // Bulk fill at the top of the address space, then sweep back.
      for (int i = 0; i < 32; i++)
         do_write(18'h3FFE0 + 18'(i), 8'(i * 7 + 3), "bulk_wr");
      rv0 = rv_cnt;
      for (int i = 0; i < 32; i++)
         do_read(18'h3FFE0 + 18'(i), 8'(i * 7 + 3), "bulk_rd");
      @(posedge CLK); #1;
      check("bulk_rv_cnt", rv_cnt - rv0, 32);
      check("oe_we_overlap", inv_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/sram_vga_arbiter.md
Name:
sram_vga_arbiter

Overview:
- Two-port arbiter and timing sequencer for the shared 256K x 8 asynchronous SRAM.
- Port R is the VGA pixel fetch. It is latency-critical and has default priority.
- Port W is the frame writer (pattern fill or image load).
- Generates sram_addr, write strobe, output enable, tristate data control and read capture, so neither client handles SRAM timing.

Parameters:
ADDR_W, 18, SRAM address width
DATA_W, 8, SRAM data width
ACCESS_CYC, 2, CLK cycles the strobe/read window is held (>=1; 2 at 150 MHz gives >=13 ns)
RD_STREAK_MAX, 4, consecutive read grants allowed while a write is pending before a write is forced

Ports:
CLK  in  1  system clock
RSTn  in  1  asynchronous active-low reset
rd_req  in  1  read request; held with rd_addr stable until rd_valid
rd_addr  in  ADDR_W  read address
rd_valid  out  1  one-cycle pulse; rd_data valid; also serves as read ack
rd_data  out  DATA_W  captured read data, held until next read completes
wr_req  in  1  write request; held with wr_addr/wr_data stable until wr_ack
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ack  out  1  one-cycle pulse; write committed
sram_addr  out  ADDR_W  registered SRAM address
sram_data  inout  DATA_W  SRAM data bus; driven only during write states
sram_we_n  out  1  write enable, active low, registered
sram_oe_n  out  1  output enable, active low, registered
sram_ce_n  out  1  chip enable; 1 in reset, 0 from first cycle after reset

Behaviour:
- Reset values (RSTn low, asynchronous):
  - state=IDLE; sram_we_n=1, sram_oe_n=1, sram_ce_n=1.
  - Data drive released immediately.
  - rd_valid=0, wr_ack=0, rd_data=0, sram_addr=0, streak=0, cnt=0.
- Reset asserted mid-access: the access is abandoned with no ack. Clients must re-request after reset.
- States: IDLE, RD_ACC, WR_SETUP, WR_STB, WR_HOLD. cnt is $clog2(ACCESS_CYC+1) wide and is cleared on every state entry.
- IDLE arbitration, evaluated on each edge:
  - Only rd_req: grant R.
  - Only wr_req: grant W.
  - Both: grant R unless streak==RD_STREAK_MAX, then grant W.
- streak counter:
  - Increments on each R grant while wr_req=1.
  - Clears on a W grant or any cycle with wr_req=0.
  - Saturates at RD_STREAK_MAX.
- Read:
  - Grant edge: sram_addr<=rd_addr, sram_oe_n<=0, enter RD_ACC.
  - RD_ACC lasts ACCESS_CYC cycles. On its last edge: rd_data<=sram_data, rd_valid<=1, sram_oe_n<=1, return to IDLE.
  - rd_valid rises ACCESS_CYC edges after the grant edge.
  - Read issue period is ACCESS_CYC+1 cycles; the IDLE cycle is the bus turnaround.
- Write:
  - Grant edge: sram_addr<=wr_addr, data register<=wr_data, drive enable<=1, enter WR_SETUP for 1 cycle. we_n stays 1 for address setup.
  - WR_STB: sram_we_n=0 for ACCESS_CYC cycles.
  - WR_HOLD, 1 cycle: we_n=1, data still driven, wr_ack<=1.
  - Then IDLE with drive released.
  - Write period is ACCESS_CYC+3 cycles.
- Invariants: the bus is never driven while sram_oe_n=0; we_n and oe_n are never both 0.
- Requests dropped mid-access are ignored. The access completes and still pulses ack/valid.
- The address passes through unmodified; there is no wrap logic. Clients own address range and wrap.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
- Defined:
  - Adds output wr_stall_cnt (16 bits).
  - Counts cycles with wr_req=1 while the state is not a write state and no W grant occurs.
  - Saturates at 16'hFFFF. Cleared by reset only.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package sram_arb_pkg holds:
  - State encoding constants.
  - Default ADDR_W/DATA_W.
  - The ack/valid pulse width constant (1).
- One sub-module, sram_io_phy:
  - Registered we_n/oe_n/ce_n/addr.
  - Tristate assign with the drive-enable register.
  - Read capture register.
- The arbiter FSM stays in the top module.

Test Plan:
- Single read, rd_addr=18'h12C00 with model data 8'hEF → oe_n low 2 cycles, rd_valid pulses at grant+2, rd_data=8'hEF, bus never driven.
- Single write, wr_addr=18'd76799 and wr_data=8'h2F → we_n low exactly 2 cycles, addr/data stable from setup through hold, wr_ack at grant+3, readback gives 8'h2F.
- rd_req and wr_req both held continuously → grant pattern R,R,R,R,W repeating; no write waits longer than 4 read periods.
- Reset pulse during WR_STB → we_n=1 and bus Z within the same cycle, no wr_ack, and memory unchanged at the checked address if the model supports it.
- 153600 back-to-back writes then sweep reads → every readback matches the written pattern and rd_valid count equals 153600.
- With SRAM_ARB_STATS_EN, a write pending during 4 reads of 3 cycles each → wr_stall_cnt=12.
